// File: rtl/cpu_req_gen.sv
// cpu_req_gen: CPU-side traffic generator placed in front of the cache top.
// It runs one pass that writes each address and reads it straight back, then a
// second pass that reads every address again. Returned data is compared under
// the access-size mask, and the result is reported on done/pass/timeout/err_cnt.
module cpu_req_gen #(
    parameter int unsigned N_ACCESS    = 30,
    parameter logic [31:0] ADDR_BASE   = 32'd0,
    parameter logic [31:0] ADDR_STRIDE = 32'd1,
    parameter logic [31:0] DATA_SEED   = 32'd30,
    parameter logic [1:0]  INS_TYPE    = 2'd0,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        Req_CPU,
    output logic        Wr_CPU,
    output logic [31:0] A_CPU,
    output logic [31:0] DI_CPU,
    output logic [1:0]  Ins_Type,
    input  logic        Rdy_CPU,
    input  logic [31:0] DO_CPU,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_cnt
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Bits of DO_CPU that take part in the read-back compare for this access size
    localparam logic [31:0] CMP_MASK = (INS_TYPE == 2'd1) ? 32'h0000_FFFF :
                                       (INS_TYPE == 2'd2) ? 32'h0000_00FF :
                                                            32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        SW_REQ,
        SW_GAP,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] idx;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [WD_W-1:0] wd_cnt;

    logic        last_idx;
    logic        rd_miss;
    logic [15:0] err_inc;
    logic [31:0] next_addr;
    logic [31:0] next_data;
    logic        wd_expire;

    // Derived values used by the state machine: end-of-sweep, compare result,
    // saturating error increment, next address/data and watchdog expiry
    always_comb begin
        last_idx  = (idx == 16'(N_ACCESS - 1));
        rd_miss   = ((DO_CPU ^ cur_data) & CMP_MASK) != '0;
        err_inc   = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
        next_addr = cur_addr + ADDR_STRIDE;
        next_data = cur_data + 32'd1;
        wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
    end

    // Sequencer: request/gap handshake, read-back checking, watchdog and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            Req_CPU  <= 1'b0;
            Wr_CPU   <= 1'b0;
            A_CPU    <= '0;
            DI_CPU   <= '0;
            Ins_Type <= INS_TYPE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
            idx      <= '0;
            cur_addr <= ADDR_BASE;
            cur_data <= DATA_SEED;
            wd_cnt   <= '0;
        end else begin
            Ins_Type <= INS_TYPE;
            case (state)
                IDLE, DONE: begin
                    // A start pulse here wins over any Rdy_CPU on the same edge
                    if (start) begin
                        state    <= WR_REQ;
                        Req_CPU  <= 1'b1;
                        Wr_CPU   <= 1'b1;
                        A_CPU    <= ADDR_BASE;
                        DI_CPU   <= DATA_SEED;
                        idx      <= '0;
                        cur_addr <= ADDR_BASE;
                        cur_data <= DATA_SEED;
                        wd_cnt   <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        timeout  <= 1'b0;
                        err_cnt  <= '0;
                    end
                end

                WR_REQ, RD_REQ, SW_REQ: begin
                    if (Rdy_CPU) begin
                        Req_CPU <= 1'b0;
                        if (state != WR_REQ && rd_miss) begin
                            err_cnt <= err_inc;
                        end
                        case (state)
                            WR_REQ:  state <= WR_GAP;
                            RD_REQ:  state <= RD_GAP;
                            default: state <= SW_GAP;
                        endcase
                    end else if (wd_expire) begin
                        state   <= DONE;
                        Req_CPU <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                        err_cnt <= err_inc;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                WR_GAP: begin
                    state   <= RD_REQ;
                    Req_CPU <= 1'b1;
                    Wr_CPU  <= 1'b0;
                    A_CPU   <= cur_addr;
                    DI_CPU  <= '0;
                    wd_cnt  <= '0;
                end

                RD_GAP: begin
                    Req_CPU <= 1'b1;
                    wd_cnt  <= '0;
                    if (last_idx) begin
                        state    <= SW_REQ;
                        idx      <= '0;
                        cur_addr <= ADDR_BASE;
                        cur_data <= DATA_SEED;
                        Wr_CPU   <= 1'b0;
                        A_CPU    <= ADDR_BASE;
                        DI_CPU   <= '0;
                    end else begin
                        state    <= WR_REQ;
                        idx      <= idx + 16'd1;
                        cur_addr <= next_addr;
                        cur_data <= next_data;
                        Wr_CPU   <= 1'b1;
                        A_CPU    <= next_addr;
                        DI_CPU   <= next_data;
                    end
                end

                SW_GAP: begin
                    if (last_idx) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        state    <= SW_REQ;
                        idx      <= idx + 16'd1;
                        cur_addr <= next_addr;
                        cur_data <= next_data;
                        Req_CPU  <= 1'b1;
                        Wr_CPU   <= 1'b0;
                        A_CPU    <= next_addr;
                        DI_CPU   <= '0;
                        wd_cnt   <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_req_gen.sv
// Bench for cpu_req_gen: a memory-model slave with configurable readiness and
// read corruption, plus a request scoreboard filled when each run is started.
module tb_cpu_req_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        Req_CPU, Wr_CPU, Rdy_CPU;
    logic [31:0] A_CPU, DI_CPU, DO_CPU;
    logic [1:0]  Ins_Type;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;

    logic        start_b;
    logic        Req_b, Wr_b, Rdy_b;
    logic [31:0] A_b, DI_b, DO_b;
    logic [1:0]  Ins_b;
    logic        busy_b, done_b, pass_b, timeout_b;
    logic [15:0] err_b;

    // slave behaviour controls
    logic        delay_odd = 1'b0;
    logic        hold0     = 1'b0;
    logic        corrupt   = 1'b0;
    logic [3:0]  wcnt;
    logic [31:0] mem  [0:63];
    logic [31:0] memb [0:63];

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;
    req_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int pops = 0;
    int pops_b = 0;
    int req_hi = 0;
    logic        pend;
    logic        pw;
    logic [31:0] pa, pd;

    always #5 clk = ~clk;

    cpu_req_gen #(.N_ACCESS(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Req_CPU(Req_CPU), .Wr_CPU(Wr_CPU), .A_CPU(A_CPU), .DI_CPU(DI_CPU),
        .Ins_Type(Ins_Type), .Rdy_CPU(Rdy_CPU), .DO_CPU(DO_CPU),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
    );

    cpu_req_gen #(.N_ACCESS(4), .INS_TYPE(2'd2)) dutb (
        .clk(clk), .rst(rst), .start(start_b),
        .Req_CPU(Req_b), .Wr_CPU(Wr_b), .A_CPU(A_b), .DI_CPU(DI_b),
        .Ins_Type(Ins_b), .Rdy_CPU(Rdy_b), .DO_CPU(DO_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .err_cnt(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave for the main instance: ready is combinational from the request
    assign Rdy_CPU = Req_CPU && !hold0 && (!delay_odd || !A_CPU[0] || (wcnt >= 4'd5));
    assign DO_CPU  = mem[A_CPU[5:0]] ^ ((corrupt && A_CPU == 32'd2) ? 32'h1 : 32'h0);

    // Slave for the byte instance: always ready, upper bytes of read data are junk
    assign Rdy_b = Req_b;
    assign DO_b  = {24'hFFFFFF, memb[A_b[5:0]][7:0]};

    always @(posedge clk) begin
        wcnt <= (Req_CPU && !Rdy_CPU) ? wcnt + 4'd1 : 4'd0;
        if (!rst && Req_CPU && Rdy_CPU && Wr_CPU) mem[A_CPU[5:0]] <= DI_CPU;
        if (!rst && Req_b && Rdy_b && Wr_b) memb[A_b[5:0]] <= DI_b;
    end

    // Monitor: request stability while waiting, scoreboard pops on completions
    always @(negedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (Req_CPU && pend) begin
                chk("hold_a", A_CPU, pa);
                chk("hold_di", DI_CPU, pd);
                chk("hold_wr", Wr_CPU, pw);
            end
            if (Req_CPU && Rdy_CPU) begin
                chk("ins", Ins_Type, 32'd0);
                if (sb.size() == 0) begin
                    chk("sb_extra", sb.size(), 32'd1);
                end else begin
                    req_t e;
                    e = sb.pop_front();
                    chk("req_wr", Wr_CPU, e.wr);
                    chk("req_a", A_CPU, e.a);
                    chk("req_di", DI_CPU, e.d);
                end
                pops <= pops + 1;
            end
            if (Req_CPU) req_hi <= req_hi + 1;
            pend <= Req_CPU && !Rdy_CPU;
            pa   <= A_CPU;
            pd   <= DI_CPU;
            pw   <= Wr_CPU;
            if (Req_b && Rdy_b) begin
                chk("b_ins", Ins_b, 32'd2);
                pops_b <= pops_b + 1;
            end
        end
    end

    task automatic push_run();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b1, 32'(i), 32'(30 + i)});
            sb.push_back('{1'b0, 32'(i), 32'd0});
        end
        for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 32'(i), 32'd0});
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 32'hDEADBEEF;
            memb[i] = 32'hDEADBEEF;
        end
    endtask

    // Called at a negedge; counts posedges from start assertion until done is seen
    task automatic run_main(input int mid_start, output int cycles);
        start  = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (mid_start != 0 && cycles == mid_start);
            if (cycles == 1) chk("req_rise", Req_CPU, 32'd1);
        end while (!done && cycles < 400);
        if (!done) chk("run_bound", done, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, Req_CPU, 32'd0);
        chk({tag, "_wr"}, Wr_CPU, 32'd0);
        chk({tag, "_a"}, A_CPU, 32'd0);
        chk({tag, "_di"}, DI_CPU, 32'd0);
        chk({tag, "_ins"}, Ins_Type, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_done"}, done, 32'd0);
        chk({tag, "_pass"}, pass, 32'd0);
        chk({tag, "_tmo"}, timeout, 32'd0);
        chk({tag, "_err"}, err_cnt, 32'd0);
    endtask

    initial begin
        int cyc;
        int guard;
        rst = 1'b1;
        start = 1'b0;
        start_b = 1'b0;
        fill_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        chk("rst_ins_b", Ins_b, 32'd2);
        rst = 1'b0;
        @(negedge clk);

        // ideal zero-latency slave
        push_run();
        run_main(0, cyc);
        chk("t1_cycles", cyc, 32'd25);
        chk("t1_pass", pass, 32'd1);
        chk("t1_err", err_cnt, 32'd0);
        chk("t1_tmo", timeout, 32'd0);
        chk("t1_busy", busy, 32'd0);
        chk("t1_sb", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_done_hold", done, 32'd1);

        // odd addresses answer after 5 extra cycles
        fill_mem();
        delay_odd = 1'b1;
        push_run();
        run_main(0, cyc);
        delay_odd = 1'b0;
        chk("t2_cycles", cyc, 32'd55);
        chk("t2_pass", pass, 32'd1);
        chk("t2_err", err_cnt, 32'd0);
        chk("t2_sb", sb.size(), 32'd0);

        // address 2 read back with bit 0 flipped; a start mid-run must be ignored
        fill_mem();
        corrupt = 1'b1;
        push_run();
        run_main(10, cyc);
        corrupt = 1'b0;
        chk("t3_cycles", cyc, 32'd25);
        chk("t3_err", err_cnt, 32'd2);
        chk("t3_pass", pass, 32'd0);
        chk("t3_done", done, 32'd1);
        chk("t3_tmo", timeout, 32'd0);
        chk("t3_sb", sb.size(), 32'd0);

        // slave never answers: watchdog aborts after 16 request cycles
        hold0 = 1'b1;
        req_hi = 0;
        run_main(0, cyc);
        @(negedge clk);
        hold0 = 1'b0;
        chk("t4_req_cycles", req_hi, 32'd16);
        chk("t4_cycles", cyc, 32'd17);
        chk("t4_tmo", timeout, 32'd1);
        chk("t4_err", err_cnt, 32'd1);
        chk("t4_done", done, 32'd1);
        chk("t4_pass", pass, 32'd0);
        chk("t4_req", Req_CPU, 32'd0);

        // reset while the fifth request is pending
        fill_mem();
        push_run();
        pops = 0;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        guard = 0;
        while (pops < 4 && guard < 100) begin
            @(posedge clk);
            #2 guard++;
        end
        chk("t5_pops", pops, 32'd4);
        @(posedge clk);
        #2 chk("t5_req5", Req_CPU, 32'd1);
        chk("t5_a5", A_CPU, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #2 chk_reset_vals("t5");
        rst = 1'b0;
        chk("t5_sb_left", sb.size(), 32'd8);
        sb.delete();
        @(negedge clk);
        push_run();
        run_main(0, cyc);
        chk("t5_cycles", cyc, 32'd25);
        chk("t5_pass", pass, 32'd1);
        chk("t5_err", err_cnt, 32'd0);
        chk("t5_sb", sb.size(), 32'd0);

        // byte-size instance: only [7:0] is compared
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        guard = 0;
        while (!done_b && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("b_done", done_b, 32'd1);
        chk("b_pass", pass_b, 32'd1);
        chk("b_err", err_b, 32'd0);
        chk("b_tmo", timeout_b, 32'd0);
        chk("b_pops", pops_b, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
